// File: rtl/if_stage_fetch.sv
// MIPS IF stage: owns PC, addresses imem combinationally, registers instr + PC+4 into IF/ID (1 edge latency).
// Redirect beats stall and inserts a bubble; stall freezes PC, IF/ID and fetch counter without a bubble.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      // Wrong-path instruction on imem_instr is dropped; target is word-aligned down.
      pc_d    = {redirect_target[31:2], 2'b00};
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      instr_d = imem_instr;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios then random stall/redirect traffic against a transaction-level model.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: what the fetch stage should architecturally hold.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  longint      m_cnt;

  always #5 clk = ~clk;

  // Word-indexed instruction memory: mem[0]=8C010000, mem[1]=8C020001, ...
  function automatic logic [31:0] memf(input logic [31:0] addr);
    logic [29:0] idx;
    logic [7:0]  hi;
    idx = addr[31:2];
    hi  = idx[7:0] + 8'd1;
    return {8'h8C, hi, idx[15:0]};
  endfunction

  assign imem_instr = memf(imem_addr);

  if_stage_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .pc              (pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ":pc"},        pc,             m_pc);
    chk({where, ":imem_addr"}, imem_addr,      m_pc);
    chk({where, ":instr"},     if_id_instr,    m_instr);
    chk({where, ":pc4"},       if_id_pc_plus4, m_pc4);
    chk({where, ":valid"},     {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({where, ":count"},     fetch_count,    m_cnt[31:0]);
  endtask

  // Called at edge+1; applies inputs, advances one clock, updates the model, checks.
  task automatic step(input string where, input logic s, input logic rv, input logic [31:0] tgt);
    logic [31:0] fetched;
    stall = s; redirect_valid = rv; redirect_target = tgt;
    #1;
    fetched = memf(m_pc);
    @(posedge clk);
    if (rv) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = fetched;
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    #1;
    check_all(where);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    #2;
    do_reset();

    // Free-running fetch: addresses 0,4,8,12
    for (int i = 0; i < 4; i++) step("run", 1'b0, 1'b0, 32'h0);
    chk("run:count4", fetch_count, 32'd4);
    chk("run:first_instr_shape", memf(32'h0), 32'h8C01_0000);

    // Stall at pc=8
    do_reset();
    step("pre_stall", 1'b0, 1'b0, 32'h0);
    step("pre_stall", 1'b0, 1'b0, 32'h0);
    chk("stall:pc_is_8", pc, 32'h8);
    step("stall1", 1'b1, 1'b0, 32'h0);
    step("stall2", 1'b1, 1'b0, 32'h0);
    chk("stall:pc4_held", if_id_pc_plus4, 32'h8);
    step("release", 1'b0, 1'b0, 32'h0);
    chk("release:pc12", pc, 32'hC);
    chk("release:mem2", if_id_instr, 32'h8C03_0002);

    // Redirect wins over stall
    step("redir_stall", 1'b1, 1'b1, 32'h18);
    chk("redir:pc18", pc, 32'h18);
    chk("redir:count_held", fetch_count, 32'd3);

    // Misaligned target aligns down
    step("misalign", 1'b0, 1'b1, 32'h27);
    chk("misalign:pc24", pc, 32'h24);
    step("misalign_fetch", 1'b0, 1'b0, 32'h0);
    chk("misalign:mem9", if_id_instr, 32'h8C0A_0009);

    // PC wrap
    step("wrap_redir", 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 1'b0, 32'h0);
    chk("wrap:pc0", pc, 32'h0);
    chk("wrap:pc4_0", if_id_pc_plus4, 32'h0);

    // Asynchronous reset between edges with pc=0x10, IF/ID valid
    step("ar_redir", 1'b0, 1'b1, 32'hC);
    step("ar_run", 1'b0, 1'b0, 32'h0);
    chk("ar:pc10", pc, 32'h10);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic s, rv;
      logic [31:0] t;
      s  = ($urandom % 4) == 0;
      rv = ($urandom % 8) == 0;
      t  = $urandom;
      step("rand", s, rv, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
